// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the core Memory stage (C) and an auxiliary master (A).
// Contention policy: fixed priority with starvation escape, or round-robin when DMEM_ARB_RR_EN is defined.
module dmem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            Rst_n,
    input  logic            c_req,
    input  logic            c_we,
    input  logic [DW/8-1:0] c_be,
    input  logic [AW-1:0]   c_addr,
    input  logic [DW-1:0]   c_wdata,
    output logic [DW-1:0]   c_rdata,
    output logic            c_ack,
    output logic            mem_hold,
    input  logic            a_req,
    input  logic            a_we,
    input  logic [DW/8-1:0] a_be,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_wdata,
    output logic [DW-1:0]   a_rdata,
    output logic            a_ack,
    output logic [DW/8-1:0] mem_en,
    output logic            mem_wea,
    output logic            mem_rea,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_din,
    input  logic [DW-1:0]   mem_dout,
    output logic            grant_a
);
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    state_t            state, state_nxt;
    logic              sel_a, we_r;
    logic [DW/8-1:0]   be_r;
    logic [AW-1:0]     addr_r;
    logic [DW-1:0]     din_r, c_rdata_q, a_rdata_q;
    logic [CW-1:0]     rd_cnt;
    logic              any_req, pick_a, rd_done, done;

    assign any_req = c_req | a_req;
    assign rd_done = (state == RDWAIT) && (rd_cnt == CW'(RD_LAT - 1));

`ifdef DMEM_ARB_RR_EN
    logic last_a;

    // Under contention the requester that did not win last time goes next.
    assign pick_a = a_req & (~c_req | ~last_a);

    always_ff @(posedge clk) begin
        if (!Rst_n)
            last_a <= 1'b1;
        else if (state == IDLE && any_req)
            last_a <= pick_a;
    end
`else
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;
    logic          contend;

    // Core wins contention until it has won STARVE_MAX in a row, then A gets one grant.
    assign contend = c_req & a_req;
    assign pick_a  = a_req & (~c_req | (starve_cnt == SW'(STARVE_MAX)));

    always_ff @(posedge clk) begin
        if (!Rst_n)
            starve_cnt <= '0;
        else if (state == IDLE) begin
            if (contend && !pick_a)
                starve_cnt <= starve_cnt + SW'(1);
            else
                starve_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_r ? IDLE : RDWAIT;
            RDWAIT:  if (rd_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Acks are masked by reset so an access aborted mid-flight never completes.
    always_comb begin
        mem_en  = '0;
        mem_wea = 1'b0;
        mem_rea = 1'b0;
        done    = 1'b0;
        case (state)
            ISSUE: begin
                mem_en  = be_r;
                mem_wea = we_r;
                mem_rea = ~we_r;
                done    = we_r;
            end
            RDWAIT:  done = rd_done;
            default: ;
        endcase
        done    = done & Rst_n;
        c_ack   = done & ~sel_a;
        a_ack   = done & sel_a;
        grant_a = sel_a & (state != IDLE);
    end

    assign mem_addr = addr_r;
    assign mem_din  = din_r;
    assign mem_hold = c_req & ~c_ack;
    assign c_rdata  = (c_ack & ~we_r) ? mem_dout : c_rdata_q;
    assign a_rdata  = (a_ack & ~we_r) ? mem_dout : a_rdata_q;

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            sel_a     <= 1'b0;
            we_r      <= 1'b0;
            be_r      <= '0;
            addr_r    <= '0;
            din_r     <= '0;
            rd_cnt    <= '0;
            c_rdata_q <= '0;
            a_rdata_q <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                sel_a  <= pick_a;
                we_r   <= pick_a ? a_we    : c_we;
                be_r   <= pick_a ? a_be    : c_be;
                addr_r <= pick_a ? a_addr  : c_addr;
                din_r  <= pick_a ? a_wdata : c_wdata;
                rd_cnt <= '0;
            end
            if (state == RDWAIT)
                rd_cnt <= rd_cnt + CW'(1);
            if (rd_done) begin
                if (sel_a) a_rdata_q <= mem_dout;
                else       c_rdata_q <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus pushes expected acks, a negedge monitor pops and checks.
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        Rst_n;
    logic        c_req, c_we, a_req, a_we;
    logic [3:0]  c_be, a_be;
    logic [31:0] c_addr, c_wdata, a_addr, a_wdata;
    logic [31:0] c_rdata, a_rdata, mem_addr, mem_din;
    logic [31:0] mem_dout = '0;
    logic        c_ack, a_ack, mem_hold, mem_wea, mem_rea, grant_a;
    logic [3:0]  mem_en;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit          is_a;
        bit          we;
        int          cyc;
        logic [31:0] rd;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] mem [0:255];

    dmem_port_arbiter dut (
        .clk(clk), .Rst_n(Rst_n),
        .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack), .mem_hold(mem_hold),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .mem_en(mem_en), .mem_wea(mem_wea), .mem_rea(mem_rea),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .grant_a(grant_a)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one cycle read latency and byte-enabled writes.
    always @(posedge clk) begin
        if (mem_rea) mem_dout <= mem[mem_addr[9:2]];
        if (mem_wea)
            for (int b = 0; b < 4; b++)
                if (mem_en[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_din[8*b +: 8];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (c_ack || a_ack) begin
            if (c_ack && a_ack)
                chk("dual_ack", 32'd1, 32'd0);
            else if (sb_q.size() == 0)
                chk("unexpected_ack", {31'd0, a_ack}, 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ack_src", {31'd0, a_ack}, {31'd0, e.is_a});
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("grant_a", {31'd0, grant_a}, {31'd0, e.is_a});
                if (!e.we) chk(e.is_a ? "a_rdata" : "c_rdata", e.is_a ? a_rdata : c_rdata, e.rd);
            end
        end
    end

    task automatic do_req(input bit is_a, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input int lat);
        int  n;
        bit  got;
        @(posedge clk); #1;
        if (is_a) begin a_req = 1; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata; end
        else      begin c_req = 1; c_we = we; c_be = be; c_addr = addr; c_wdata = wdata; end
        n = cyc;
        sb_q.push_back('{is_a, we, n + lat, exp_rd});
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (cyc == n + 1) begin
                chk("issue_en",   {28'd0, mem_en}, {28'd0, be});
                chk("issue_wea",  {31'd0, mem_wea}, {31'd0, we});
                chk("issue_rea",  {31'd0, mem_rea}, {31'd0, ~we});
                chk("issue_addr", mem_addr, addr);
                chk("issue_din",  mem_din, wdata);
            end
            if (!is_a) chk("mem_hold", {31'd0, mem_hold}, {31'd0, cyc < n + lat});
            if (is_a ? a_ack : c_ack) got = 1;
        end
        if (is_a) a_req = 0; else c_req = 0;
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n, acks;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        Rst_n = 0;
        c_req = 1; c_we = 0; c_be = 0; c_addr = 0; c_wdata = 0;
        a_req = 1; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;

        // Reset held two cycles with both requesting.
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); @(negedge clk);
            chk("rst_mem_en",  {28'd0, mem_en}, 32'd0);
            chk("rst_strobes", {30'd0, mem_wea, mem_rea}, 32'd0);
            chk("rst_acks",    {30'd0, c_ack, a_ack}, 32'd0);
            chk("rst_grant_a", {31'd0, grant_a}, 32'd0);
            chk("rst_c_rdata", c_rdata, 32'd0);
            chk("rst_a_rdata", a_rdata, 32'd0);
            chk("rst_addr",    mem_addr, 32'd0);
            chk("rst_din",     mem_din, 32'd0);
            chk("rst_hold",    {31'd0, mem_hold}, 32'd1);
        end
        c_req = 0; a_req = 0; Rst_n = 1;

        do_req(0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0, 1);
        do_req(0, 0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        @(negedge clk);
        chk("a_rdata_untouched", a_rdata, 32'd0);
        chk("c_rdata_held", c_rdata, 32'hDEADBEEF);

        do_req(0, 1, 4'h0, 32'h104, 32'h12345678, 32'h0, 1);
        do_req(0, 0, 4'hF, 32'h104, 32'h0, 32'h0, 2);
        do_req(1, 1, 4'h3, 32'h200, 32'hCAFEF00D, 32'h0, 1);
        do_req(1, 0, 4'hF, 32'h200, 32'h0, 32'h0000F00D, 2);
        @(negedge clk);
        chk("c_rdata_after_aux", c_rdata, 32'h0);

        // Both hold write requests through 18 grants.
        @(posedge clk); #1;
        c_req = 1; c_we = 1; c_be = 4'hF; c_addr = 32'h300; c_wdata = 32'd1;
        a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 32'h304; a_wdata = 32'd2;
        n = cyc;
        for (int k = 0; k < 18; k++) begin
`ifdef DMEM_ARB_RR_EN
            sb_q.push_back('{(k % 2) == 1, 1'b1, n + 1 + 2*k, 32'h0});
`else
            sb_q.push_back('{(k % 9) == 8, 1'b1, n + 1 + 2*k, 32'h0});
`endif
        end
        acks = 0;
        for (int k = 0; k < 60 && acks < 18; k++) begin
            @(negedge clk);
            if (c_ack || a_ack) acks++;
        end
        c_req = 0; a_req = 0;
        chk("contention_acks", 32'(acks), 32'd18);

        // Reset lands while an aux read sits in RDWAIT.
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_be = 4'hF; a_addr = 32'h200; a_wdata = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_issue_rea", {31'd0, mem_rea}, 32'd1);
        @(posedge clk); #1;
        Rst_n = 0; a_req = 0;
        @(negedge clk);
        chk("abort_no_ack", {31'd0, a_ack}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_grant_a", {31'd0, grant_a}, 32'd0);
        chk("abort_rea",     {31'd0, mem_rea}, 32'd0);
        chk("abort_a_rdata", a_rdata, 32'd0);
        Rst_n = 1;

        do_req(0, 1, 4'hF, 32'h108, 32'h55AA55AA, 32'h0, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
